cpu_axi_bridge: RTL and testbench

- Converts the CPU core's two SRAM-like request ports (inst, data) into one AXI3 master.
- Sits directly downstream of the CPU top. Consumes its req/addr_ok/data_ok traffic and drives the AXI crossbar.
- Allows at most one outstanding read and one outstanding write.
- Data port has priority over the inst port on the read channel.

---
 rtl/cpu_axi_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// =============================================================================
// cpu_axi_bridge : inst/data SRAM-like request ports merged onto one AXI3 master
// Revision       : 1.0
// =============================================================================
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // inst port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AR / R
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AW / W / B
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2} wstate_t;

  rstate_t     r_rstate;
  wstate_t     r_wstate;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic        r_arvalid;
  logic        r_rready;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;

  logic w_data_rd_busy;
  logic w_data_port_idle;
  logic w_data_rd_req;
  logic w_data_rd_acc;
  logic w_data_wr_acc;
  logic w_inst_rd_acc;
  logic w_r_fire;
  logic w_b_fire;
  logic w_aw_done;
  logic w_w_done;
  logic w_unused_inst;

  // The inst port is read-only; its write fields are intentionally dropped.
  assign w_unused_inst = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid};

  // Data requests are serialised: one data transaction in flight across both FSMs.
  assign w_data_rd_busy   = (r_rstate != R_IDLE) && (r_arid == DATA_ID);
  assign w_data_port_idle = !w_data_rd_busy && (r_wstate == W_IDLE);
  assign w_data_rd_req    = data_sram_req && !data_sram_wr;

  assign w_data_rd_acc = resetn && (r_rstate == R_IDLE) && w_data_rd_req && w_data_port_idle;
  assign w_data_wr_acc = resetn && (r_wstate == W_IDLE) && data_sram_req && data_sram_wr
                         && w_data_port_idle;
  assign w_inst_rd_acc = resetn && (r_rstate == R_IDLE) && inst_sram_req && !w_data_rd_req;

  assign w_r_fire  = r_rready && rvalid;
  assign w_b_fire  = r_bready && bvalid;
  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid || wready;

  assign inst_sram_addr_ok = w_inst_rd_acc;
  assign data_sram_addr_ok = w_data_rd_acc || w_data_wr_acc;
  assign inst_sram_data_ok = w_r_fire && (r_arid == INST_ID);
  assign data_sram_data_ok = (w_r_fire && (r_arid == DATA_ID)) || w_b_fire;
  assign inst_sram_rdata   = inst_sram_data_ok ? rdata : 32'd0;
  assign data_sram_rdata   = (w_r_fire && (r_arid == DATA_ID)) ? rdata : 32'd0;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;
  assign awaddr  = r_awaddr;
  assign awsize  = r_awsize;
  assign awvalid = r_awvalid;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_arid    <= 4'd0;
      r_araddr  <= 32'd0;
      r_arsize  <= 3'd0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_data_rd_acc) begin
            r_arid    <= DATA_ID;
            r_araddr  <= data_sram_addr;
            r_arsize  <= {1'b0, data_sram_size};
            r_arvalid <= 1'b1;
            r_rstate  <= R_AR;
          end else if (w_inst_rd_acc) begin
            r_arid    <= INST_ID;
            r_araddr  <= inst_sram_addr;
            r_arsize  <= {1'b0, inst_sram_size};
            r_arvalid <= 1'b1;
            r_rstate  <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rstate  <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // AW and W retire independently; B is awaited only once both have landed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= 32'd0;
      r_awsize  <= 3'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_data_wr_acc) begin
            r_awaddr  <= data_sram_addr;
            r_awsize  <= {1'b0, data_sram_size};
            r_wdata   <= data_sram_wdata;
            r_wstrb   <= data_sram_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wstate  <= W_REQ;
          end
        end
        W_REQ: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_wstate <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// Bench for cpu_axi_bridge: transaction-level reference model, reactive AXI slave,
// directed scenarios with literal expectations, then a randomized run.
module tb_cpu_axi_bridge;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = 2'd2;
  logic [3:0]  inst_sram_wstrb = 4'd0;
  logic [31:0] inst_sram_addr = 32'd0, inst_sram_wdata = 32'd0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
  logic [1:0]  data_sram_size = 2'd2;
  logic [3:0]  data_sram_wstrb = 4'd0;
  logic [31:0] data_sram_addr = 32'd0, data_sram_wdata = 32'd0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize;
  logic [3:0]  wstrb;

  cpu_axi_bridge #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference model: at most one outstanding read and one outstanding write record.
  logic        m_rd_busy = 1'b0, m_rd_data = 1'b0, m_rd_ar_done = 1'b0;
  logic [31:0] m_rd_addr = 32'd0;
  logic [1:0]  m_rd_size = 2'd0;
  logic        m_wr_busy = 1'b0, m_wr_aw_done = 1'b0, m_wr_w_done = 1'b0;
  logic [31:0] m_wr_addr = 32'd0, m_wr_data = 32'd0;
  logic [1:0]  m_wr_size = 2'd0;
  logic [3:0]  m_wr_strb = 4'd0;

  // Slave knobs and state; rnd_mode draws per-transaction delays at random.
  bit          rnd_mode = 1'b0;
  int          k_ar = 0, k_r = 0, k_aw = 0, k_w = 0, k_b = 0;
  logic [31:0] k_rdata = 32'd0;
  bit          sl_rd_pend = 1'b0, sl_aw_got = 1'b0, sl_w_got = 1'b0;
  logic [3:0]  sl_rd_id = 4'd0;
  int          sl_ar_wait, sl_ar_delay, sl_rd_wait, sl_r_delay;
  int          sl_aw_wait, sl_aw_delay, sl_w_wait, sl_w_delay, sl_b_wait, sl_b_delay;

  // Snapshot of DUT outputs from the most recent sample point.
  logic        s_iaok, s_daok, s_idok, s_ddok, s_arvalid, s_rready, s_awvalid, s_wvalid;
  logic [31:0] s_irdata, s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_arid, s_wstrb;
  logic [2:0]  s_arsize, s_awsize;

  function automatic int pick(input int k);
    return rnd_mode ? int'($urandom_range(0, 3)) : k;
  endfunction

  task automatic slave_clear();
    sl_rd_pend = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0;
    sl_ar_wait = 0; sl_rd_wait = 0; sl_aw_wait = 0; sl_w_wait = 0; sl_b_wait = 0;
    sl_ar_delay = pick(k_ar); sl_r_delay = pick(k_r);
    sl_aw_delay = pick(k_aw); sl_w_delay = pick(k_w); sl_b_delay = pick(k_b);
  endtask

  // One clock: slave drives at negedge, outputs compared against the model, both advance.
  task automatic cycle();
    logic e_iaok, e_daok, e_ar, e_rr, e_aw, e_w, e_b, e_idok, e_ddok, dfree, dread;
    @(negedge clk);
    arready = arvalid && (sl_ar_wait >= sl_ar_delay);
    rvalid  = sl_rd_pend && (sl_rd_wait >= sl_r_delay);
    rid     = sl_rd_id;
    rdata   = rnd_mode ? $urandom : k_rdata;
    awready = awvalid && (sl_aw_wait >= sl_aw_delay);
    wready  = wvalid && (sl_w_wait >= sl_w_delay);
    bvalid  = sl_aw_got && sl_w_got && (sl_b_wait >= sl_b_delay);
    #1;
    dfree  = !(m_rd_busy && m_rd_data) && !m_wr_busy;
    dread  = data_sram_req && !data_sram_wr;
    e_daok = resetn && data_sram_req && dfree && (data_sram_wr || !m_rd_busy);
    e_iaok = resetn && inst_sram_req && !m_rd_busy && !dread;
    e_ar   = resetn && m_rd_busy && !m_rd_ar_done;
    e_rr   = resetn && m_rd_busy && m_rd_ar_done;
    e_aw   = resetn && m_wr_busy && !m_wr_aw_done;
    e_w    = resetn && m_wr_busy && !m_wr_w_done;
    e_b    = resetn && m_wr_busy && m_wr_aw_done && m_wr_w_done;
    e_idok = e_rr && rvalid && !m_rd_data;
    e_ddok = (e_rr && rvalid && m_rd_data) || (e_b && bvalid);

    chk1("inst_addr_ok", inst_sram_addr_ok, e_iaok);
    chk1("data_addr_ok", data_sram_addr_ok, e_daok);
    chk1("arvalid", arvalid, e_ar);
    chk1("rready", rready, e_rr);
    chk1("awvalid", awvalid, e_aw);
    chk1("wvalid", wvalid, e_w);
    chk1("bready", bready, e_b);
    chk1("inst_data_ok", inst_sram_data_ok, e_idok);
    chk1("data_data_ok", data_sram_data_ok, e_ddok);
    if (e_ar) begin
      chk("araddr", araddr, m_rd_addr);
      chk("arid", {28'd0, arid}, {28'd0, (m_rd_data ? DATA_ID : INST_ID)});
      chk("arsize", {29'd0, arsize}, {30'd0, m_rd_size});
    end
    if (e_rr && rvalid) chk("rid_known", {28'd0, rid}, {28'd0, (m_rd_data ? DATA_ID : INST_ID)});
    if (e_idok) chk("inst_rdata", inst_sram_rdata, rdata);
    if (e_rr && rvalid && m_rd_data) chk("data_rdata", data_sram_rdata, rdata);
    if (e_aw) begin
      chk("awaddr", awaddr, m_wr_addr);
      chk("awsize", {29'd0, awsize}, {30'd0, m_wr_size});
    end
    if (e_w) begin
      chk("wdata", wdata, m_wr_data);
      chk("wstrb", {28'd0, wstrb}, {28'd0, m_wr_strb});
    end

    s_iaok = inst_sram_addr_ok; s_daok = data_sram_addr_ok;
    s_idok = inst_sram_data_ok; s_ddok = data_sram_data_ok; s_irdata = inst_sram_rdata;
    s_arvalid = arvalid; s_araddr = araddr; s_arid = arid; s_arsize = arsize; s_rready = rready;
    s_awvalid = awvalid; s_awaddr = awaddr; s_awsize = awsize;
    s_wvalid = wvalid; s_wdata = wdata; s_wstrb = wstrb;

    if (!resetn) begin
      m_rd_busy = 1'b0; m_wr_busy = 1'b0;
    end else begin
      if (e_rr && rvalid) m_rd_busy = 1'b0;
      else if (e_ar && arready) m_rd_ar_done = 1'b1;
      if (e_daok && !data_sram_wr) begin
        m_rd_busy = 1'b1; m_rd_data = 1'b1; m_rd_ar_done = 1'b0;
        m_rd_addr = data_sram_addr; m_rd_size = data_sram_size;
      end else if (e_iaok) begin
        m_rd_busy = 1'b1; m_rd_data = 1'b0; m_rd_ar_done = 1'b0;
        m_rd_addr = inst_sram_addr; m_rd_size = inst_sram_size;
      end
      if (e_b && bvalid) m_wr_busy = 1'b0;
      else begin
        if (e_aw && awready) m_wr_aw_done = 1'b1;
        if (e_w && wready)   m_wr_w_done  = 1'b1;
      end
      if (e_daok && data_sram_wr) begin
        m_wr_busy = 1'b1; m_wr_aw_done = 1'b0; m_wr_w_done = 1'b0;
        m_wr_addr = data_sram_addr; m_wr_size = data_sram_size;
        m_wr_strb = data_sram_wstrb; m_wr_data = data_sram_wdata;
      end
    end

    if (rvalid && rready) sl_rd_pend = 1'b0;
    else if (sl_rd_pend) sl_rd_wait++;
    if (arvalid && arready) begin
      sl_rd_pend = 1'b1; sl_rd_id = arid; sl_rd_wait = 0; sl_r_delay = pick(k_r);
      sl_ar_wait = 0; sl_ar_delay = pick(k_ar);
    end else if (arvalid) sl_ar_wait++;
    if (bvalid && bready) begin
      sl_aw_got = 1'b0; sl_w_got = 1'b0;
    end else if (sl_aw_got && sl_w_got) sl_b_wait++;
    if (awvalid && awready) begin
      sl_aw_got = 1'b1; sl_aw_wait = 0; sl_aw_delay = pick(k_aw);
      sl_b_wait = 0; sl_b_delay = pick(k_b);
    end else if (awvalid) sl_aw_wait++;
    if (wvalid && wready) begin
      sl_w_got = 1'b1; sl_w_wait = 0; sl_w_delay = pick(k_w);
    end else if (wvalid) sl_w_wait++;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] d);
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = a;
    data_sram_size = sz; data_sram_wstrb = st; data_sram_wdata = d;
  endtask

  initial begin
    slave_clear();
    // Reset with requests present: nothing may be accepted.
    inst_sram_req = 1'b1; data_sram_req = 1'b1;
    cycle();
    chk1("rst_inst_addr_ok", s_iaok, 1'b0);
    chk1("rst_data_addr_ok", s_daok, 1'b0);
    chk1("rst_arvalid", s_arvalid, 1'b0);
    chk1("rst_awvalid", s_awvalid, 1'b0);
    chk("rst_araddr", s_araddr, 32'd0);
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    cycle();
    resetn = 1'b1;
    cycle();

    // Inst read with immediate slave.
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000; inst_sram_size = 2'd2;
    k_rdata = 32'h3C08_0001;
    cycle();
    chk1("t1_addr_ok_c0", s_iaok, 1'b1);
    inst_sram_req = 1'b0;
    cycle();
    chk1("t1_arvalid_c1", s_arvalid, 1'b1);
    chk("t1_arid_c1", {28'd0, s_arid}, 32'd0);
    chk("t1_araddr_c1", s_araddr, 32'hBFC0_0000);
    chk("t1_arsize_c1", {29'd0, s_arsize}, 32'd2);
    cycle();
    chk1("t1_data_ok_c2", s_idok, 1'b1);
    chk("t1_rdata_c2", s_irdata, 32'h3C08_0001);
    cycle();

    // Inst and data reads in the same cycle.
    begin : t2
      int dok, iacc, idok;
      dok = -1; iacc = -1; idok = -1;
      inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0010;
      data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_1000;
      data_sram_size = 2'd2; k_rdata = 32'hA5A5_0001;
      cycle();
      chk1("t2_data_aok_first", s_daok, 1'b1);
      chk1("t2_inst_waits", s_iaok, 1'b0);
      data_sram_req = 1'b0;
      for (int i = 1; i < 12; i++) begin
        cycle();
        if (s_ddok && dok < 0) dok = i;
        if (s_iaok && iacc < 0) begin iacc = i; inst_sram_req = 1'b0; end
        if (s_idok && idok < 0) idok = i;
      end
      chk("t2_data_ok_cycle", dok, 2);
      chk("t2_inst_aok_cycle", iacc, 3);
      chk("t2_inst_dok_cycle", idok, 5);
    end

    // Store word, wready three cycles ahead of awready.
    begin : t3
      int n, at;
      n = 0; at = -1;
      k_aw = 3; slave_clear();
      store(32'h1FAF_0000, 2'd2, 4'hF, 32'h1234_5678);
      cycle();
      chk1("t3_addr_ok", s_daok, 1'b1);
      data_sram_req = 1'b0;
      cycle();
      chk("t3_awsize", {29'd0, s_awsize}, 32'd2);
      chk("t3_wdata", s_wdata, 32'h1234_5678);
      chk("t3_wstrb", {28'd0, s_wstrb}, 32'hF);
      for (int i = 2; i < 14; i++) begin
        cycle();
        if (s_ddok) begin n++; at = i; end
      end
      chk("t3_dok_count", n, 1);
      chk("t3_dok_cycle", at, 5);
      k_aw = 0; slave_clear();
    end

    // Store then load of the same address.
    begin : t4
      int bok, acc;
      bok = -1; acc = -1;
      store(32'h1FAF_0100, 2'd2, 4'hF, 32'hCAFE_0001);
      cycle();
      chk1("t4_store_aok", s_daok, 1'b1);
      data_sram_wr = 1'b0;
      for (int i = 1; i < 10; i++) begin
        cycle();
        if (s_ddok && bok < 0) bok = i;
        if (s_daok && acc < 0) begin acc = i; data_sram_req = 1'b0; end
      end
      chk("t4_store_dok_cycle", bok, 2);
      chk("t4_load_aok_cycle", acc, 3);
    end

    // Reset while a read waits in the R phase.
    begin : t5
      int n;
      n = 0;
      k_r = 6; slave_clear();
      inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0020;
      cycle();
      inst_sram_req = 1'b0;
      cycle();
      cycle();
      chk1("t5_rready_before", s_rready, 1'b1);
      inst_sram_req = 1'b1; data_sram_req = 1'b1; data_sram_wr = 1'b0;
      resetn = 1'b0;
      #1;
      chk1("t5_rready_async", rready, 1'b0);
      chk1("t5_arvalid_async", arvalid, 1'b0);
      chk1("t5_inst_aok_async", inst_sram_addr_ok, 1'b0);
      chk1("t5_data_aok_async", data_sram_addr_ok, 1'b0);
      chk1("t5_bready_async", bready, 1'b0);
      inst_sram_req = 1'b0; data_sram_req = 1'b0;
      cycle();
      cycle();
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
        cycle();
        if (s_idok || s_ddok) n++;
      end
      chk("t5_no_data_ok", n, 0);
      k_r = 0; slave_clear();
    end

    // Byte store.
    store(32'h1FAF_0002, 2'd0, 4'h4, 32'h00AB_0000);
    cycle();
    chk1("t6_addr_ok", s_daok, 1'b1);
    data_sram_req = 1'b0;
    cycle();
    chk("t6_awsize", {29'd0, s_awsize}, 32'd0);
    chk("t6_wstrb", {28'd0, s_wstrb}, 32'h4);
    chk("t6_awaddr", s_awaddr, 32'h1FAF_0002);
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic.
    rnd_mode = 1'b1; slave_clear();
    for (int i = 0; i < 4000; i++) begin
      inst_sram_req   = ($urandom_range(0, 1) == 1);
      inst_sram_addr  = $urandom;
      inst_sram_size  = 2'($urandom_range(0, 2));
      data_sram_req   = ($urandom_range(0, 1) == 1);
      data_sram_wr    = ($urandom_range(0, 1) == 1);
      data_sram_addr  = $urandom;
      data_sram_size  = 2'($urandom_range(0, 2));
      data_sram_wstrb = 4'($urandom);
      data_sram_wdata = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
